// File: rtl/stopwatch_ctrl.sv
// Start/stop/zero stopwatch: prescaled tick gated by an IDLE/RUN/PAUSE FSM into a BCD digit chain.
// Optional lap/split display freeze is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 500000,
  parameter int TICK_W   = 20
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start_stop,
  input  logic                  zero,
  input  logic                  lap,
  output logic [4*N_DIGITS-1:0] disp,
  output logic                  running,
  output logic                  overflow,
  output logic                  lap_active
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [TICK_W-1:0] LP_PRESC_LAST = TICK_W'(TICK_DIV - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [TICK_W-1:0]     r_presc;
  logic [TICK_W-1:0]     w_presc_next;
  logic [4*N_DIGITS-1:0] r_digits;
  logic [4*N_DIGITS-1:0] w_digits_inc;
  logic [4*N_DIGITS-1:0] w_digits_next;
  logic [N_DIGITS:0]     w_carry;
  logic                  w_tick;
  logic                  w_zero_req;
  logic                  r_running;
  logic                  r_overflow;

  assign w_tick     = (r_state == ST_RUN) && (r_presc == LP_PRESC_LAST);
  assign w_zero_req = (r_state == ST_PAUSE) && zero;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start_stop) w_state_next = ST_RUN;
      ST_RUN:   if (start_stop) w_state_next = ST_PAUSE;
      ST_PAUSE: begin
        if (zero)            w_state_next = ST_IDLE;
        else if (start_stop) w_state_next = ST_RUN;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Prescaler advances only in RUN; PAUSE keeps the partial period for resume.
  always_comb begin
    w_presc_next = '0;
    case (r_state)
      ST_RUN:   w_presc_next = w_tick ? '0 : r_presc + TICK_W'(1);
      ST_PAUSE: w_presc_next = zero ? '0 : r_presc;
      default:  w_presc_next = '0;
    endcase
  end

  assign w_carry[0] = w_tick;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    logic [3:0] w_digit;
    assign w_digit          = r_digits[4*gi +: 4];
    assign w_carry[gi+1]    = w_carry[gi] && (w_digit == 4'd9);
    assign w_digits_inc[4*gi +: 4] = !w_carry[gi]      ? w_digit :
                                     (w_digit == 4'd9) ? 4'd0    : w_digit + 4'd1;
  end

  assign w_digits_next = w_zero_req ? '0 : w_digits_inc;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state    <= ST_IDLE;
      r_presc    <= '0;
      r_digits   <= '0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_presc   <= w_presc_next;
      r_digits  <= w_digits_next;
      r_running <= (w_state_next == ST_RUN);
      if (w_zero_req)
        r_overflow <= 1'b0;
      else if (w_carry[N_DIGITS])
        r_overflow <= 1'b1;
    end
  end

  assign running  = r_running;
  assign overflow = r_overflow;

`ifdef STOPWATCH_LAP_EN
  logic                  r_lap_active;
  logic                  w_lap_active_next;
  logic                  w_capture;
  logic [4*N_DIGITS-1:0] r_disp;
  logic [4*N_DIGITS-1:0] w_disp_next;

  always_comb begin
    w_lap_active_next = r_lap_active;
    w_capture         = 1'b0;
    if (w_zero_req) begin
      w_lap_active_next = 1'b0;
    end else if (lap) begin
      case (r_state)
        ST_RUN: begin
          w_lap_active_next = 1'b1;
          w_capture         = 1'b1;
        end
        ST_PAUSE: w_lap_active_next = 1'b0;
        default:  w_lap_active_next = r_lap_active;
      endcase
    end
    // A capture snapshots what the display currently shows, not the post-tick value.
    if (w_capture)
      w_disp_next = r_digits;
    else if (w_lap_active_next)
      w_disp_next = r_disp;
    else
      w_disp_next = w_digits_next;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_lap_active <= 1'b0;
      r_disp       <= '0;
    end else begin
      r_lap_active <= w_lap_active_next;
      r_disp       <= w_disp_next;
    end
  end

  assign disp       = r_disp;
  assign lap_active = r_lap_active;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign disp         = r_digits;
  assign lap_active   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (N_DIGITS=2, TICK_DIV=4): directed scenarios plus randomized
// control pulses, compared every cycle against an integer-count model of the stopwatch.
module tb_stopwatch_ctrl;

  localparam int N_DIG = 2;
  localparam int DIV   = 4;
  localparam int TW    = 3;
  localparam int MAXV  = 100;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic             clk = 1'b0;
  logic             clear = 1'b1;
  logic             start_stop = 1'b0;
  logic             zero = 1'b0;
  logic             lap = 1'b0;
  logic [4*N_DIG-1:0] disp;
  logic             running;
  logic             overflow;
  logic             lap_active;

  int  checks = 0;
  int  failures = 0;
  int  lap_events = 0;
  bit  check_en = 1'b0;

  int  m_state = M_IDLE;
  int  m_count = 0;
  int  m_presc = 0;
  int  m_lap_val = 0;
  bit  m_ovf = 1'b0;
  bit  m_lap_act = 1'b0;

  stopwatch_ctrl #(
    .N_DIGITS (N_DIG),
    .TICK_DIV (DIV),
    .TICK_W   (TW)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .start_stop (start_stop),
    .zero       (zero),
    .lap        (lap),
    .disp       (disp),
    .running    (running),
    .overflow   (overflow),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [7:0] exp_disp();
    return m_lap_act ? to_bcd(m_lap_val) : to_bcd(m_count);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the stopwatch as an integer count with a cycle-counted tick.
  task automatic model_step(input bit ss, input bit z, input bit lp, input bit clr);
    bit tick;
    int old_count;
    int nstate;
    if (clr) begin
      m_state = M_IDLE; m_count = 0; m_presc = 0; m_lap_val = 0;
      m_ovf = 1'b0; m_lap_act = 1'b0;
    end else begin
      tick      = (m_state == M_RUN) && (m_presc == DIV - 1);
      old_count = m_count;
      nstate    = m_state;
      if (m_state == M_IDLE && ss)       nstate = M_RUN;
      else if (m_state == M_RUN && ss)   nstate = M_PAUSE;
      else if (m_state == M_PAUSE && z)  nstate = M_IDLE;
      else if (m_state == M_PAUSE && ss) nstate = M_RUN;
      if (m_state == M_RUN)        m_presc = tick ? 0 : m_presc + 1;
      else if (m_state != M_PAUSE) m_presc = 0;
      if (tick) begin
        if (m_count == MAXV - 1) m_ovf = 1'b1;
        m_count = (m_count + 1) % MAXV;
      end
`ifdef STOPWATCH_LAP_EN
      if (lp && m_state == M_RUN) begin
        m_lap_act = 1'b1;
        m_lap_val = old_count;
      end else if (lp && m_state == M_PAUSE) begin
        m_lap_act = 1'b0;
      end
`else
      if (lp) lap_events++;
`endif
      if (m_state == M_PAUSE && z) begin
        m_count = 0; m_presc = 0; m_ovf = 1'b0; m_lap_act = 1'b0;
      end
      m_state = nstate;
    end
  endtask

  task automatic step(input bit ss, input bit z, input bit lp, input bit clr);
    start_stop = ss; zero = z; lap = lp; clear = clr;
    @(posedge clk);
    model_step(ss, z, lp, clr);
    #1;
    start_stop = 1'b0; zero = 1'b0; lap = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_disp", 32'(disp), 32'(exp_disp()));
      check("cyc_running", 32'(running), 32'(m_state == M_RUN));
      check("cyc_overflow", 32'(overflow), 32'(m_ovf));
      check("cyc_lap_active", 32'(lap_active), 32'(m_lap_act));
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_en = 1'b1;
    $display("txn %0t: clear", $time);
    check("rst_disp", 32'(disp), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_lap_active", 32'(lap_active), 32'h0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    $display("txn %0t: start, 40 cycles", $time);
    check("run40_disp", 32'(disp), 32'h10);
    check("run40_running", 32'(running), 32'h1);

    idle(356);
    $display("txn %0t: run to 99", $time);
    check("reach99_disp", 32'(disp), 32'h99);
    idle(4);
    $display("txn %0t: wrap", $time);
    check("wrap_disp", 32'(disp), 32'h00);
    check("wrap_overflow", 32'(overflow), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    $display("txn %0t: pause then zero", $time);
    check("zero_overflow", 32'(overflow), 32'h0);
    check("zero_running", 32'(running), 32'h0);

    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    $display("txn %0t: pause held 20 cycles", $time);
    check("pause_disp", 32'(disp), 32'h00);
    check("pause_running", 32'(running), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    $display("txn %0t: resume", $time);
    check("resume_disp", 32'(disp), 32'h01);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    $display("txn %0t: zero while running", $time);
    check("zero_in_run_running", 32'(running), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    $display("txn %0t: zero+start_stop in pause", $time);
    check("zero_wins_running", 32'(running), 32'h0);
    check("zero_wins_disp", 32'(disp), 32'h00);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(148);
    $display("txn %0t: run to 37", $time);
    check("at37_disp", 32'(disp), 32'h37);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    $display("txn %0t: clear mid-run", $time);
    check("clr_disp", 32'(disp), 32'h00);
    check("clr_running", 32'(running), 32'h0);
    check("clr_overflow", 32'(overflow), 32'h0);
    check("clr_lap_active", 32'(lap_active), 32'h0);

`ifdef STOPWATCH_LAP_EN
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(48);
    check("at12_disp", 32'(disp), 32'h12);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    $display("txn %0t: lap at 12", $time);
    check("lap_disp", 32'(disp), 32'h12);
    check("lap_active_set", 32'(lap_active), 32'h1);
    idle(20);
    check("lap_hold_disp", 32'(disp), 32'h12);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    $display("txn %0t: lap release in pause", $time);
    check("lap_release_active", 32'(lap_active), 32'h0);
    check("lap_release_disp", 32'(disp), 32'h17);
`endif

    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500)
        step(($urandom % 10) == 0, ($urandom % 8) == 0, ($urandom % 6) == 0,
             ($urandom % 300) == 0);
      else
        step(($urandom % 60) == 0, ($urandom % 40) == 0, ($urandom % 12) == 0,
             ($urandom % 1000) == 0);
    end
    $display("txn %0t: random phase done", $time);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
